rtc_time_ctrl: RTL and testbench

RTC_TIME_CTRL -- requirements
Module: rtc_time_ctrl

---
 rtl/rtc_time_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_rtc_time_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_time_ctrl.sv
// RTC time controller: boots the serial RTC, polls h/m/s, and supports key-driven time editing.
// Optional alarm comparator (alarm_time/alarm_hit) is built only when RTC_ALARM_EN is defined.
module rtc_time_ctrl #(
  parameter logic [7:0] HOUR_MAX    = 8'h23,
  parameter int         WRAP        = 1,
  parameter int         POLL_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_dec,
  input  logic        key_sel,
  input  logic        cmd_done,
  input  logic [7:0]  time_read_data,
`ifdef RTC_ALARM_EN
  input  logic [23:0] alarm_time,
  output logic        alarm_hit,
`endif
  output logic [7:0]  cmd_sig,
  output logic [7:0]  time_write_data,
  output logic [23:0] rtc_time,
  output logic        config_sig,
  output logic [1:0]  sel_field
);

  typedef enum logic [3:0] {
    INIT_RH, INIT_RM, INIT_RS, WP_OFF, WR_H, WR_M, WR_S, WP_ON,
    IDLE, RD_H, RD_M, RD_S, CFG_WP_OFF, CFG_STOP, CFG_EDIT
  } state_t;

  localparam logic [16:0] POLL_LIM = 17'(POLL_CYCLES);

  state_t      state, state_nxt;
  logic [7:0]  cmd_nxt, wdata_nxt;
  logic [7:0]  fld, fld_lim, fld_new;
  logic [23:0] time_nxt;
  logic [1:0]  sel_nxt;
  logic [15:0] poll_cnt, poll_nxt;
  logic [16:0] poll_inc;
  logic        done;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return (WRAP != 0) ? 8'h00 : v;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00) return (WRAP != 0) ? lim : v;
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    return {v[7:4], v[3:0] - 4'h1};
  endfunction

  function automatic logic [7:0] cmd_of(input state_t s);
    case (s)
      INIT_RH, RD_H:      return 8'h04;
      INIT_RM, RD_M:      return 8'h02;
      INIT_RS, RD_S:      return 8'h01;
      WP_OFF, CFG_WP_OFF: return 8'h80;
      WR_H:               return 8'h40;
      WR_M:               return 8'h20;
      WR_S, CFG_STOP:     return 8'h10;
      WP_ON:              return 8'h08;
      default:            return 8'h00;
    endcase
  endfunction

  // A done pulse only counts while a command is actually outstanding.
  assign done     = cmd_done && (cmd_sig != 8'h00);
  assign poll_inc = {1'b0, poll_cnt} + 17'd1;

  always_comb begin
    fld     = rtc_time[7:0];
    fld_lim = 8'h59;
    case (sel_field)
      2'd0: begin
        fld     = rtc_time[23:16];
        fld_lim = HOUR_MAX;
      end
      2'd1:    fld = rtc_time[15:8];
      default: ;
    endcase
    fld_new = key_inc ? bcd_inc(fld, fld_lim) : bcd_dec(fld, fld_lim);
  end

  always_comb begin
    state_nxt = state;
    wdata_nxt = time_write_data;
    time_nxt  = rtc_time;
    sel_nxt   = sel_field;
    poll_nxt  = poll_cnt;
    case (state)
      INIT_RH, RD_H: if (done) begin
        time_nxt[23:16] = time_read_data;
        state_nxt       = (state == INIT_RH) ? INIT_RM : RD_M;
      end
      INIT_RM, RD_M: if (done) begin
        time_nxt[15:8] = time_read_data;
        state_nxt      = (state == INIT_RM) ? INIT_RS : RD_S;
      end
      INIT_RS, RD_S: if (done) begin
        time_nxt[7:0] = time_read_data;
        state_nxt     = (state == INIT_RS) ? WP_OFF : IDLE;
      end
      WP_OFF:     if (done) state_nxt = WR_H;
      WR_H:       if (done) state_nxt = WR_M;
      WR_M:       if (done) state_nxt = WR_S;
      WR_S:       if (done) state_nxt = WP_ON;
      WP_ON:      if (done) state_nxt = IDLE;
      CFG_WP_OFF: if (done) state_nxt = CFG_STOP;
      CFG_STOP: if (done) begin
        state_nxt = CFG_EDIT;
        sel_nxt   = 2'd0;
      end
      IDLE: begin
        if (poll_inc >= POLL_LIM) begin
          poll_nxt  = 16'd0;
          state_nxt = config_sig ? CFG_WP_OFF : RD_H;
        end else begin
          poll_nxt = poll_inc[15:0];
        end
      end
      CFG_EDIT: begin
        if (!config_sig) begin
          state_nxt = WR_H;
        end else if (!key_mode) begin
          if (key_inc || key_dec) begin
            case (sel_field)
              2'd0:    time_nxt[23:16] = fld_new;
              2'd1:    time_nxt[15:8]  = fld_new;
              default: time_nxt[7:0]   = fld_new;
            endcase
          end else if (key_sel) begin
            sel_nxt = (sel_field == 2'd2) ? 2'd0 : sel_field + 2'd1;
          end
        end
      end
      default: state_nxt = INIT_RH;
    endcase

    // Completion drops the command for one cycle; entry from IDLE/CFG_EDIT issues at once.
    cmd_nxt = done ? 8'h00 : cmd_of(state_nxt);
    case (state_nxt)
      WR_H:     wdata_nxt = time_nxt[23:16];
      WR_M:     wdata_nxt = time_nxt[15:8];
      WR_S:     wdata_nxt = {1'b0, time_nxt[6:0]};
      CFG_STOP: wdata_nxt = 8'h80;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= INIT_RH;
      cmd_sig         <= 8'h00;
      time_write_data <= 8'h00;
      rtc_time        <= 24'h000000;
      sel_field       <= 2'd0;
      poll_cnt        <= 16'd0;
      config_sig      <= 1'b0;
    end else begin
      state           <= state_nxt;
      cmd_sig         <= cmd_nxt;
      time_write_data <= wdata_nxt;
      rtc_time        <= time_nxt;
      sel_field       <= sel_nxt;
      poll_cnt        <= poll_nxt;
      if (key_mode) config_sig <= ~config_sig;
    end
  end

`ifdef RTC_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_hit <= 1'b0;
    else        alarm_hit <= (state == RD_S) && done && !config_sig && (time_nxt == alarm_time);
  end
`endif

endmodule

// File: tb/tb_rtc_time_ctrl.sv
// Bench for rtc_time_ctrl: two instances (wrapping and saturating edit) share one serial-engine model.
module tb_rtc_time_ctrl;
  localparam int          POLL_P  = 4;
  localparam logic [23:0] ALARM_T = 24'h070000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0, key_sel = 1'b0;
  logic cmd_done, eng_en = 1'b0;
  logic [7:0] rd_data;
  logic [7:0] cmd0, cmd1, wd0, wd1;
  logic [23:0] t0, t1;
  logic cfg0, cfg1;
  logic [1:0] sel0, sel1;
`ifdef RTC_ALARM_EN
  logic [23:0] alarm_time = ALARM_T;
  logic hit0, hit1;
`endif

  rtc_time_ctrl #(.HOUR_MAX(8'h23), .WRAP(1), .POLL_CYCLES(POLL_P)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .key_sel(key_sel), .cmd_done(cmd_done), .time_read_data(rd_data),
`ifdef RTC_ALARM_EN
    .alarm_time(alarm_time), .alarm_hit(hit0),
`endif
    .cmd_sig(cmd0), .time_write_data(wd0), .rtc_time(t0), .config_sig(cfg0), .sel_field(sel0));

  rtc_time_ctrl #(.HOUR_MAX(8'h23), .WRAP(0), .POLL_CYCLES(POLL_P)) dut_sat (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .key_sel(key_sel), .cmd_done(cmd_done), .time_read_data(rd_data),
`ifdef RTC_ALARM_EN
    .alarm_time(alarm_time), .alarm_hit(hit1),
`endif
    .cmd_sig(cmd1), .time_write_data(wd1), .rtc_time(t1), .config_sig(cfg1), .sel_field(sel1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] cmd;
    bit         chk_wd;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic [7:0] rd;
    bit         alarm;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int issued = 0, done_cnt = 0;
  int last_done_cyc = 0;
  logic [7:0] last_cmd = 8'h00;
  logic [7:0] m0 [3];
  logic [7:0] m1 [3];
  int msel = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int d);
    return 8'((d / 10) * 16 + d % 10);
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Reference edit: decimal +/-1 with limit handling.
  function automatic logic [7:0] edit(input logic [7:0] v, input int fld, input bit up, input bit wrap);
    int d   = from_bcd(v);
    int lim = (fld == 0) ? 23 : 59;
    if (up) d = (d == lim) ? (wrap ? 0 : d) : d + 1;
    else    d = (d == 0) ? (wrap ? lim : 0) : d - 1;
    return to_bcd(d);
  endfunction

  task automatic push(input logic [7:0] c, input bit cw, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] r, input bit a);
    exp_q.push_back('{cmd: c, chk_wd: cw, wd0: w0, wd1: w1, rd: r, alarm: a});
    issued++;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("handshake_progress", done_cnt >= target, 1);
  endtask

  task automatic check_time();
    check("time_wrap", t0, {m0[0], m0[1], m0[2]});
    check("time_sat", t1, {m1[0], m1[1], m1[2]});
  endtask

  // Serial engine + scoreboard monitor.
  initial begin : engine
    exp_t e;
    int lat;
    cmd_done = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(negedge clk);
`ifdef RTC_ALARM_EN
      if (hit0 || hit1) check("alarm_spurious", {hit0, hit1}, 0);
`endif
      if (eng_en && rst_n && cmd0 != 8'h00) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_cmd: actual %0h, expected no command", cmd0);
          e = '{cmd: cmd0, chk_wd: 1'b0, wd0: 8'h00, wd1: 8'h00, rd: 8'h00, alarm: 1'b0};
        end else begin
          e = exp_q.pop_front();
        end
        if (cmd0 == 8'h04 && last_cmd == 8'h01) check("poll_gap", cyc - last_done_cyc, POLL_P);
        check("cmd_wrap", cmd0, e.cmd);
        check("cmd_sat", cmd1, e.cmd);
        if (e.chk_wd) begin
          check("wdata_wrap", wd0, e.wd0);
          check("wdata_sat", wd1, e.wd1);
        end
        lat = $urandom_range(0, 2);
        repeat (lat) begin
          @(negedge clk);
          check("cmd_hold", cmd0, e.cmd);
        end
        cmd_done = 1'b1;
        rd_data  = e.rd;
        @(negedge clk);
        cmd_done = 1'b0;
        check("cmd_release", {cmd0, cmd1}, 0);
`ifdef RTC_ALARM_EN
        if (e.cmd == 8'h01) check("alarm_hit", {hit0, hit1}, {e.alarm, e.alarm});
`endif
        last_cmd      = e.cmd;
        last_done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic read_round(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input bit noise);
    push(8'h04, 1'b0, 8'h00, 8'h00, h, 1'b0);
    push(8'h02, 1'b0, 8'h00, 8'h00, m, 1'b0);
    push(8'h01, 1'b0, 8'h00, 8'h00, s, {h, m, s} == ALARM_T);
    if (noise) repeat (3) begin
      @(negedge clk);
      key_inc = 1'($urandom_range(0, 1));
      key_dec = 1'($urandom_range(0, 1));
      key_sel = 1'($urandom_range(0, 1));
      @(negedge clk);
      {key_inc, key_dec, key_sel} = 3'b000;
    end
    wait_done(issued);
    m0 = '{h, m, s};
    m1 = '{h, m, s};
    check_time();
  endtask

  task automatic rand_round(input bit noise, input bit ch);
    read_round(to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
               to_bcd($urandom_range(0, 59)) | {ch, 7'h00}, noise);
  endtask

  task automatic cfg_enter();
    push(8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    push(8'h10, 1'b1, 8'h80, 8'h80, 8'h00, 1'b0);
    key_mode = 1'b1;
    @(negedge clk);
    key_mode = 1'b0;
    wait_done(issued);
    msel = 0;
    check("cfg_on", {cfg0, cfg1}, 2'b11);
    check("sel_entry", {sel0, sel1}, 0);
  endtask

  task automatic edit_key(input bit km, input bit ki, input bit kd, input bit ks);
    @(negedge clk);
    {key_mode, key_inc, key_dec, key_sel} = {km, ki, kd, ks};
    @(negedge clk);
    {key_mode, key_inc, key_dec, key_sel} = 4'b0000;
    if (!km) begin
      if (ki || kd) begin
        m0[msel] = edit(m0[msel], msel, ki, 1'b1);
        m1[msel] = edit(m1[msel], msel, ki, 1'b0);
      end else if (ks) begin
        msel = (msel + 1) % 3;
      end
    end
    check_time();
    check("sel_wrap", sel0, msel);
    check("sel_sat", sel1, msel);
  endtask

  task automatic cfg_exit();
    push(8'h40, 1'b1, m0[0], m1[0], 8'h00, 1'b0);
    push(8'h20, 1'b1, m0[1], m1[1], 8'h00, 1'b0);
    push(8'h10, 1'b1, m0[2] & 8'h7F, m1[2] & 8'h7F, 8'h00, 1'b0);
    push(8'h08, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    edit_key(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(issued);
    check("cfg_off", {cfg0, cfg1}, 2'b00);
  endtask

  task automatic rand_edits(input int n);
    repeat (n) edit_key(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_cmd", {cmd0, cmd1}, 0);
    check("rst_wdata", {wd0, wd1}, 0);
    check("rst_time", t0 | t1, 0);
    check("rst_cfg_sel", {cfg0, cfg1, sel0, sel1}, 0);

    // First command issue, then reset mid-command.
    rst_n    = 1'b1;
    key_mode = 1'b1;
    @(negedge clk);
    key_mode = 1'b0;
    check("init_issue", cmd0, 8'h04);
    check("cfg_toggle", cfg0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_abandon_cmd", {cmd0, cmd1}, 0);
    check("rst_cfg_clear", {cfg0, cfg1}, 0);

    push(8'h04, 1'b0, 8'h00, 8'h00, 8'h12, 1'b0);
    push(8'h02, 1'b0, 8'h00, 8'h00, 8'h34, 1'b0);
    push(8'h01, 1'b0, 8'h00, 8'h00, 8'h56, 1'b0);
    push(8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    push(8'h40, 1'b1, 8'h12, 8'h12, 8'h00, 1'b0);
    push(8'h20, 1'b1, 8'h34, 8'h34, 8'h00, 1'b0);
    push(8'h10, 1'b1, 8'h56, 8'h56, 8'h00, 1'b0);
    push(8'h08, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    eng_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(issued);
    check("init_time", t0, 24'h123456);
    check("init_time_sat", t1, 24'h123456);

    read_round(8'h23, 8'h59, 8'h59, 1'b1);
    read_round(8'h23, 8'h00, to_bcd($urandom_range(0, 59)), 1'b0);
    cfg_enter();
    edit_key(1'b0, 1'b1, 1'b0, 1'b0);
    edit_key(1'b0, 1'b0, 1'b0, 1'b1);
    edit_key(1'b0, 1'b0, 1'b1, 1'b0);
    edit_key(1'b0, 1'b1, 1'b0, 1'b1);
    rand_edits(30);
    cfg_exit();

    for (int s = 0; s < 2; s++) begin
      rand_round(1'b1, 1'b0);
      rand_round(1'b0, 1'b0);
      rand_round(1'b1, s == 0);
      cfg_enter();
      rand_edits(25);
      cfg_exit();
    end
    rand_round(1'b1, 1'b0);

`ifdef RTC_ALARM_EN
    read_round(8'h07, 8'h00, 8'h00, 1'b0);
    push(8'h04, 1'b0, 8'h00, 8'h00, 8'h07, 1'b0);
    push(8'h02, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    push(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    push(8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    push(8'h10, 1'b1, 8'h80, 8'h80, 8'h00, 1'b0);
    wait_done(issued - 4);
    key_mode = 1'b1;
    @(negedge clk);
    key_mode = 1'b0;
    wait_done(issued);
    m0 = '{8'h07, 8'h00, 8'h00};
    m1 = '{8'h07, 8'h00, 8'h00};
    msel = 0;
    check_time();
    cfg_exit();
    rand_round(1'b0, 1'b0);
`endif

    eng_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
